fetch_seq: RTL and testbench

Fetch/branch sequencer that sits directly upstream of the SN74x163-style program counter in kwanCPU. It drives the counter's d, clr_, load_, p and t inputs. It runs a request/acknowledge fetch with instruction memory at the address the counter presents. It then decides, per fetched instruction, whether the counter increments, loads a jump target, or holds.

---
 rtl/fetch_seq_if.sv | 26 ++
 rtl/fetch_seq.sv | 65 ++++++
 tb/tb_fetch_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fetch_seq_if.sv
// fetch_seq_if: handshake/bus bundle between the fetch sequencer, instruction memory and the PC counter
//   master: sequencer side (drives mem_req and the counter controls d/clr_/load_/p/t, plus halted/fault)
//   slave : environment side (drives mem_ack, instr_jmp/halt/target and go)
interface fetch_seq_if #(parameter int N = 4);
  logic         mem_req;
  logic         mem_ack;
  logic         instr_jmp;
  logic         instr_halt;
  logic [N-1:0] instr_target;
  logic         go;
  logic [N-1:0] d;
  logic         clr_;
  logic         load_;
  logic         p;
  logic         t;
  logic         halted;
  logic         fault;
  modport master (
    input  mem_ack, instr_jmp, instr_halt, instr_target, go,
    output mem_req, d, clr_, load_, p, t, halted, fault
  );
  modport slave (
    output mem_ack, instr_jmp, instr_halt, instr_target, go,
    input  mem_req, d, clr_, load_, p, t, halted, fault
  );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: fetch/branch sequencer driving an SN74x163-style program counter
//   clk  : system clock, rising edge
//   rst_ : asynchronous active-low reset
//   bus  : fetch_seq_if.master (memory handshake, instruction fields, go, counter controls, status)
module fetch_seq #(
  parameter int N       = 4,
  parameter int TIMEOUT = 8
) (
  input logic         clk,
  input logic         rst_,
  fetch_seq_if.master bus
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] WLAST = W'(TIMEOUT - 1);
  typedef enum logic [2:0] {INIT, FETCH, EXEC, HALT, FAULT} state_t;
  state_t       state_q, state_d;
  logic         jmp_q, jmp_d, halt_q, halt_d;
  logic [N-1:0] tgt_q, tgt_d;
  logic [W-1:0] wcnt_q, wcnt_d;
  logic         ack;
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= INIT;
      jmp_q   <= 1'b0;
      halt_q  <= 1'b0;
      tgt_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      jmp_q   <= jmp_d;
      halt_q  <= halt_d;
      tgt_q   <= tgt_d;
      wcnt_q  <= wcnt_d;
    end
  end
  // an ack on the timeout edge still wins over the fault
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = FETCH;
      FETCH:   state_d = bus.mem_ack ? EXEC : (wcnt_q == WLAST) ? FAULT : FETCH;
      EXEC:    state_d = halt_q ? HALT : FETCH;
      HALT:    state_d = bus.go ? FETCH : HALT;
      default: state_d = FAULT;
    endcase
  end
  // the wait counter only runs across consecutive unacknowledged FETCH cycles
  always_comb begin
    ack    = (state_q == FETCH) && bus.mem_ack;
    jmp_d  = ack ? bus.instr_jmp : jmp_q;
    halt_d = ack ? bus.instr_halt : halt_q;
    tgt_d  = ack ? bus.instr_target : tgt_q;
    wcnt_d = (state_q == FETCH && !bus.mem_ack) ? wcnt_q + W'(1) : '0;
  end
  always_comb begin
    bus.mem_req = state_q == FETCH;
    bus.clr_    = state_q != INIT;
    bus.load_   = !(state_q == EXEC && jmp_q);
    bus.p       = state_q == EXEC && !jmp_q;
    bus.t       = state_q == EXEC && !jmp_q;
    bus.halted  = state_q == HALT;
    bus.fault   = state_q == FAULT;
    bus.d       = tgt_q;
  end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: randomized self-checking bench for fetch_seq with a behavioural PC counter and instruction-level model
module tb_fetch_seq;
  localparam int N  = 4;
  localparam int TO = 8;
  logic         clk  = 1'b0;
  logic         rst_ = 1'b0;
  logic [N-1:0] q    = '1;
  logic [N-1:0] exp_pc = '0;
  int           n_cmp = 0;
  int           n_err = 0;
  fetch_seq_if #(.N(N)) bus();
  fetch_seq #(.N(N), .TIMEOUT(TO)) dut (.clk(clk), .rst_(rst_), .bus(bus));
  always #5 clk = ~clk;
  // downstream 163-style counter: clear beats load beats count
  always @(posedge clk)
    q <= !bus.clr_ ? '0 : !bus.load_ ? bus.d : (bus.p && bus.t) ? q + 1'b1 : q;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic noise();
    bus.instr_jmp    = 1'($urandom);
    bus.instr_halt   = 1'($urandom);
    bus.instr_target = N'($urandom);
  endtask
  task automatic chk_fetch();
    check("fetch_req", 32'(bus.mem_req), 1);
    check("fetch_clr", 32'(bus.clr_), 1);
    check("fetch_load", 32'(bus.load_), 1);
    check("fetch_pt", 32'({bus.p, bus.t}), 0);
    check("fetch_halted", 32'(bus.halted), 0);
    check("fetch_fault", 32'(bus.fault), 0);
    check("fetch_q", 32'(q), 32'(exp_pc));
  endtask
  task automatic do_reset();
    rst_ = 1'b0;
    #1;
    check("rst_clr", 32'(bus.clr_), 0);
    check("rst_req", 32'(bus.mem_req), 0);
    check("rst_fault", 32'(bus.fault), 0);
    check("rst_halted", 32'(bus.halted), 0);
    check("rst_load", 32'(bus.load_), 1);
    check("rst_pt", 32'({bus.p, bus.t}), 0);
    check("rst_d", 32'(bus.d), 0);
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    exp_pc = '0;
    chk_fetch();
  endtask
  // one instruction: dly unacknowledged FETCH cycles, ack, EXEC, then optional HALT for hold+1 cycles
  task automatic run_instr(input int dly, input bit jmp, input bit halt, input logic [N-1:0] tgt, input int hold);
    for (int i = 0; i < dly; i++) begin
      chk_fetch();
      bus.mem_ack = 1'b0;
      bus.go = 1'($urandom);
      noise();
      @(negedge clk);
    end
    chk_fetch();
    bus.mem_ack = 1'b1;
    bus.instr_jmp = jmp;
    bus.instr_halt = halt;
    bus.instr_target = tgt;
    bus.go = 1'($urandom);
    @(negedge clk);
    bus.mem_ack = 1'($urandom);
    bus.go = 1'($urandom);
    noise();
    check("exec_req", 32'(bus.mem_req), 0);
    check("exec_load", 32'(bus.load_), 32'(!jmp));
    check("exec_pt", 32'({bus.p, bus.t}), jmp ? 0 : 3);
    if (jmp) check("exec_d", 32'(bus.d), 32'(tgt));
    check("exec_q", 32'(q), 32'(exp_pc));
    @(negedge clk);
    exp_pc = jmp ? tgt : exp_pc + 1'b1;
    bus.mem_ack = 1'b0;
    bus.go = 1'b0;
    if (halt) begin
      for (int i = 0; i < hold; i++) begin
        check("halt_halted", 32'(bus.halted), 1);
        check("halt_req", 32'(bus.mem_req), 0);
        check("halt_ctl", 32'({bus.load_, bus.p, bus.t}), 4);
        check("halt_q", 32'(q), 32'(exp_pc));
        bus.mem_ack = 1'($urandom);
        @(negedge clk);
      end
      check("halt_halted", 32'(bus.halted), 1);
      check("halt_q", 32'(q), 32'(exp_pc));
      bus.go = 1'b1;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      bus.go = 1'b0;
    end
  endtask
  initial begin
    bus.mem_ack = 1'b0;
    bus.instr_jmp = 1'b0;
    bus.instr_halt = 1'b0;
    bus.instr_target = '0;
    bus.go = 1'b0;
    @(negedge clk);
    do_reset();
    repeat (5) run_instr(0, 0, 0, '0, 0);
    check("at5", 32'(exp_pc), 5);
    run_instr(0, 1, 0, 4'b0010, 0);
    repeat (16) run_instr(0, 0, 0, '0, 0);
    repeat (5) run_instr(0, 0, 0, '0, 0);
    run_instr(0, 0, 1, '0, 10);
    run_instr(1, 1, 1, 4'd3, 2);
    repeat (150)
      run_instr($urandom_range(0, TO - 1), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                N'($urandom), $urandom_range(0, 4));
    run_instr(TO - 1, 0, 0, '0, 0);
    for (int i = 0; i < TO; i++) begin
      chk_fetch();
      bus.mem_ack = 1'b0;
      noise();
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      check("to_fault", 32'(bus.fault), 1);
      check("to_req", 32'(bus.mem_req), 0);
      check("to_halted", 32'(bus.halted), 0);
      check("to_q", 32'(q), 32'(exp_pc));
      bus.go = 1'b1;
      bus.mem_ack = 1'($urandom);
      @(negedge clk);
    end
    bus.go = 1'b0;
    bus.mem_ack = 1'b0;
    #2;
    do_reset();
    run_instr(0, 1, 0, 4'd9, 0);
    #2;
    do_reset();
    run_instr(0, 0, 0, '0, 0);
    run_instr(2, 0, 0, '0, 0);
    chk_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
